// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the CPU/DMA RAM port arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant picker for two requesters.
// RAM_ARB_RR_EN selects round-robin on ties; otherwise CPU has strict priority.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_dma,
  output logic cpu_gnt,
  output logic dma_gnt
);

`ifdef RAM_ARB_RR_EN
  // On a tie, the requester that did not win last time goes first.
  assign cpu_gnt = cpu_req & (~dma_req | last_dma);
  assign dma_gnt = dma_req & (~cpu_req | ~last_dma);
`else
  logic unused_last;
  assign unused_last = last_dma;
  assign cpu_gnt     = cpu_req;
  assign dma_gnt     = dma_req & ~cpu_req;
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between CPU and DMA: grant, issue registers, read tag pipe.
// Optional macro RAM_ARB_RR_EN switches tie-breaking to round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              arb_busy
);

  logic              last_dma;
  logic              ram_we_reg, ram_we_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
  owner_t            owner_q1_reg, owner_q1_next;
  owner_t            owner_q2_reg;

  ram_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .last_dma (last_dma),
    .cpu_gnt  (cpu_gnt),
    .dma_gnt  (dma_gnt)
  );

`ifdef RAM_ARB_RR_EN
  logic last_dma_reg;

  // Reset to DMA so that the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dma_reg <= 1'b1;
    end else if (cpu_gnt) begin
      last_dma_reg <= 1'b0;
    end else if (dma_gnt) begin
      last_dma_reg <= 1'b1;
    end
  end

  assign last_dma = last_dma_reg;
`else
  assign last_dma = 1'b1;
`endif

  always_comb begin
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = '0;
    owner_q1_next  = OWN_NONE;
    if (cpu_gnt) begin
      ram_we_next    = cpu_we;
      ram_addr_next  = cpu_addr;
      ram_wdata_next = cpu_wdata;
      owner_q1_next  = cpu_we ? OWN_NONE : OWN_CPU;
    end else if (dma_gnt) begin
      ram_we_next    = dma_we;
      ram_addr_next  = dma_addr;
      ram_wdata_next = dma_wdata;
      owner_q1_next  = dma_we ? OWN_NONE : OWN_DMA;
    end
  end

  // Clearing both tag stages on reset drops any read already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      owner_q1_reg  <= OWN_NONE;
      owner_q2_reg  <= OWN_NONE;
    end else begin
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      owner_q1_reg  <= owner_q1_next;
      owner_q2_reg  <= owner_q1_reg;
    end
  end

  assign ram_we     = ram_we_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_wdata  = ram_wdata_reg;

  assign cpu_rvalid = (owner_q2_reg == OWN_CPU);
  assign dma_rvalid = (owner_q2_reg == OWN_DMA);
  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;
  assign arb_busy   = (owner_q1_reg != OWN_NONE) || (owner_q2_reg != OWN_NONE);

endmodule
